// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, enums and schedule helpers for the SDF FFT sequencer
// Purpose: default FFT geometry, stage mode / FSM enums, per-stage delay and offset helpers.
// Ports: none (package).
package fft_pkg;

  localparam int FFT_LOG2N = 9;
  localparam int FFT_PIPE  = 1;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int FFT_LAT   = FFT_N - 1 + FFT_LOG2N * FFT_PIPE;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_DELAY = 2'd1,
    MODE_BFLY  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Delay-line length of stage s.
  function automatic int d_of(input int log2n, input int s);
    return (1 << log2n) >> (s + 1);
  endfunction

  // Step at which the first sample reaches stage s.
  function automatic int off_of(input int log2n, input int pipe, input int s);
    return (1 << log2n) - ((1 << log2n) >> s) + s * pipe;
  endfunction

  // Input-to-output latency of the whole pipeline, in steps.
  function automatic int lat_of(input int log2n, input int pipe);
    return (1 << log2n) - 1 + log2n * pipe;
  endfunction

endpackage

// File: rtl/fft_stage_seq.sv
// rtl/fft_stage_seq.sv - per-stage mode and twiddle address decode from the shared counters
// Purpose: combinational decode of one stage's FILL/DELAY/BFLY mode and twiddle address.
// Ports: cnt (wrapping step counter), lat (saturating step counter) -> mode, tw_addr.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int LOG2N = 9,
  parameter int PIPE  = 1,
  parameter int TW_W  = 8,
  parameter int LATW  = 10,
  parameter int S     = 0
) (
  input  logic [LOG2N-1:0] cnt,
  input  logic [LATW-1:0]  lat,
  output mode_e            mode,
  output logic [TW_W-1:0]  tw_addr
);

  localparam int D   = d_of(LOG2N, S);
  localparam int OFF = off_of(LOG2N, PIPE, S);
  localparam int ARM = OFF + D;

  // 2*D divides N, so working modulo N and then masking gives (cnt - OFF) mod 2*D.
  localparam logic [LOG2N-1:0] OFF_V  = LOG2N'(OFF % (1 << LOG2N));
  localparam logic [LOG2N-1:0] MASK_D = LOG2N'(D - 1);

  logic [LOG2N-1:0] diff;
  logic [LOG2N-1:0] low;
  logic             armed;
  logic             bfly;

  assign diff  = cnt - OFF_V;
  assign low   = diff & MASK_D;
  assign armed = (lat >= LATW'(ARM));
  // Bit log2(D) of diff is set exactly when c_s >= D.
  assign bfly  = diff[LOG2N-1-S];

  always_comb begin
    mode    = MODE_FILL;
    tw_addr = '0;
    if (armed) begin
      if (bfly) begin
        mode = MODE_BFLY;
      end else begin
        mode = MODE_DELAY;
        if (S != LOG2N - 1) tw_addr = TW_W'(low << S);
      end
    end
  end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - central step sequencer for the radix-2 SDF FFT pipeline
// Purpose: counts accepted samples, drives every stage's mode and twiddle address, flushes the
//          pipeline after the stream stops and flags the bit-reversed output window.
// Ports: clk, rst_n (async active-low); in_valid/in_ready input handshake; stage_mode and
//        tw_addr packed per stage; out_valid/out_index output window; frame_done and
//        err_partial one-cycle pulses.
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int PIPE  = FFT_PIPE,
  parameter int TW_W  = FFT_LOG2N - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*LOG2N-1:0]      stage_mode,
  output logic [TW_W*LOG2N-1:0]   tw_addr,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        out_index,
  output logic                    frame_done,
  output logic                    err_partial
);

  localparam int N    = 1 << LOG2N;
  localparam int LAT  = lat_of(LOG2N, PIPE);
  localparam int LATW = $clog2(LAT + 1);
  localparam logic [LOG2N-1:0] LAT_MOD = LOG2N'(LAT % N);

  state_e                  state;
  logic [LOG2N-1:0]        cnt;
  logic [LATW-1:0]         lat;
  logic [LATW-1:0]         flush_cnt;
  logic                    step;
  logic [2*LOG2N-1:0]      mode_vec;
  logic [TW_W*LOG2N-1:0]   tw_vec;

  // in_ready is low exactly while flushing, so this is accepted-sample OR flush step.
  assign step = (in_valid & in_ready) | (state == ST_FLUSH);

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    mode_e            m;
    logic [TW_W-1:0]  t;
    fft_stage_seq #(
      .LOG2N (LOG2N),
      .PIPE  (PIPE),
      .TW_W  (TW_W),
      .LATW  (LATW),
      .S     (s)
    ) u_seq (
      .cnt     (cnt),
      .lat     (lat),
      .mode    (m),
      .tw_addr (t)
    );
    assign mode_vec[2*s +: 2]     = m;
    assign tw_vec[TW_W*s +: TW_W] = t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat         <= '0;
      flush_cnt   <= '0;
      in_ready    <= 1'b1;
      stage_mode  <= '0;
      tw_addr     <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      frame_done  <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_partial <= 1'b0;
      out_valid   <= step && (lat >= LATW'(LAT));
      out_index   <= (step && (lat >= LATW'(LAT))) ? cnt - LAT_MOD : '0;

      // Outputs capture the schedule of the step being taken; they hold while the
      // stream pauses between RUN and FLUSH and clear once the controller is idle.
      if (step) begin
        cnt        <= cnt + LOG2N'(1);
        if (lat < LATW'(LAT)) lat <= lat + LATW'(1);
        stage_mode <= mode_vec;
        tw_addr    <= tw_vec;
      end else if (state == ST_IDLE) begin
        stage_mode <= '0;
        tw_addr    <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (in_valid) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!in_valid) begin
            state       <= ST_FLUSH;
            in_ready    <= 1'b0;
            flush_cnt   <= LATW'(LAT);
            err_partial <= (cnt != '0);
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - LATW'(1);
          // Last flush step: counter reaches 0 on this edge.
          if (flush_cnt == LATW'(1)) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            frame_done <= 1'b1;
            cnt        <= '0;
            lat        <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
